// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: op codes, RV32 opcode and
// funct fields, the canonical NOP word and the controller state type.
package instr_enc_pkg;

  // Op codes accepted on op_i; every other value is illegal.
  typedef enum logic [3:0] {
    OP_OR   = 4'd0,
    OP_AND  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8
  } op_e;

  // RV32 major opcodes
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERR   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Op request and instruction-memory write bus of the instruction encoder.
//
// Handshakes:
//   op channel : an op is transferred on a rising edge where op_valid_i and
//                op_ready_o are both high. op_ready_o does not depend on
//                op_valid_i; the requester holds op_i and its fields stable
//                while op_valid_i is high and not yet accepted.
//   mem channel: mem_we_o, mem_addr_o and mem_data_o stay stable while
//                mem_we_o is high; the write completes on the rising edge
//                where mem_ack_i is sampled high with mem_we_o high. An ack
//                seen while mem_we_o is low has no effect.
interface instr_encoder_if;
  logic        start_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [3:0]  op_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [11:0] imm_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic        full_o;
  logic        err_o;

  // Encoder side
  modport slave (
    input  start_i, op_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, mem_ack_i,
    output op_ready_o, mem_we_o, mem_addr_o, mem_data_o, full_o, err_o
  );

  // Requester / memory side
  modport master (
    output start_i, op_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, mem_ack_i,
    input  op_ready_o, mem_we_o, mem_addr_o, mem_data_o, full_o, err_o
  );
endinterface

// File: rtl/instr_enc_fmt.sv
// Combinational RV32 word formatter: turns an op code plus register and
// immediate fields into an instruction word and flags illegal op codes.
// Illegal op codes produce word 0; the caller decides what to do with them.
module instr_enc_fmt
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  // Select the instruction format and assemble its fields.
  always_comb begin
    word_o  = 32'h0000_0000;
    legal_o = 1'b1;
    case (op_i)
      OP_OR:   word_o = {F7_BASE, rs2_i, rs1_i, F3_OR,  rd_i, OPC_RTYPE};
      OP_AND:  word_o = {F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OPC_RTYPE};
      OP_ADD:  word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i, OPC_RTYPE};
      OP_SUB:  word_o = {F7_SUB,  rs2_i, rs1_i, F3_ADD, rd_i, OPC_RTYPE};
      OP_MUL:  word_o = {F7_MUL,  rs2_i, rs1_i, F3_ADD, rd_i, OPC_RTYPE};
      OP_ADDI: word_o = {imm_i, rs1_i, F3_ADDI, rd_i, OPC_OPIMM};
      OP_LW:   word_o = {imm_i, rs1_i, F3_WORD, rd_i, OPC_LOAD};
      OP_SW:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
      // imm_i carries branch offset bits [12:1]
      OP_BEQ:  word_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, F3_BEQ,
                         imm_i[3:0], imm_i[10], OPC_BRANCH};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts op requests, formats them into RV32 words and
// writes them to consecutive word addresses of an instruction memory starting
// at ADDR_BASE, stopping after DEPTH words until restarted.
//
// Build option INSTR_ENC_ILLEGAL_TRAP_EN: when defined, an accepted illegal op
// enters ERR and raises the sticky err_o without writing; when undefined, an
// illegal op is written as a NOP and err_o is constant 0.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instr_encoder_if.slave        bus,
  output enc_state_e            state_o,
  output logic [31:0]           cnt_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  enc_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]       fmt_word;
  logic              fmt_legal;
  logic              op_ready;
  logic              mem_we;
  logic              full;
  logic              accept;
  logic              last_word;

  instr_enc_fmt u_fmt (
    .op_i    (bus.op_i),
    .rd_i    (bus.rd_i),
    .rs1_i   (bus.rs1_i),
    .rs2_i   (bus.rs2_i),
    .imm_i   (bus.imm_i),
    .word_o  (fmt_word),
    .legal_o (fmt_legal)
  );

  // A restart in the same cycle wins over a new op, so no op is taken then.
  assign accept    = bus.op_valid_i & op_ready;
  assign last_word = (cnt_q == CNT_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: restart has priority, then op acceptance and write completion
  always_comb begin
    state_d = state_q;
    if (bus.start_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
            state_d = fmt_legal ? ST_WRITE : ST_ERR;
`else
            state_d = ST_WRITE;
`endif
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack_i) state_d = last_word ? ST_FULL : ST_IDLE;
        end
        // FULL and ERR are left only by restart or reset
        default: state_d = state_q;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    op_ready = 1'b0;
    mem_we   = 1'b0;
    full     = 1'b0;
    case (state_q)
      ST_IDLE:  op_ready = ~bus.start_i;
      ST_WRITE: mem_we   = 1'b1;
      ST_FULL:  full     = 1'b1;
      default:  ;
    endcase
  end

  // Address, word and counter: load on accept, advance on completed write
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (bus.start_i) begin
      addr_d = ADDR_BASE;
      cnt_d  = '0;
    end else if (accept) begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
      if (fmt_legal) data_d = fmt_word;
`else
      data_d = fmt_legal ? fmt_word : NOP_WORD;
`endif
    end else if (state_q == ST_WRITE && bus.mem_ack_i) begin
      addr_d = addr_q + 32'd4;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= ADDR_BASE;
      data_q <= 32'h0000_0000;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  logic err_q, err_d;

  // Sticky illegal-op flag, cleared only by restart or reset
  always_comb begin
    err_d = err_q;
    if (bus.start_i)               err_d = 1'b0;
    else if (accept && !fmt_legal) err_d = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.op_ready_o = op_ready;
  assign bus.mem_we_o   = mem_we;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.full_o     = full;
  assign state_o        = state_q;
  assign cnt_o          = 32'(cnt_q);

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 SHALL have parameter DEPTH, default 256: maximum number of words written before full.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  restart: clears the word counter and error, and returns the address to ADDR_BASE.
REQ-006 op_valid_i  in  1  op request valid.
REQ-007 op_ready_o  out  1  op request accepted when high together with op_valid_i.
REQ-008 op_i  in  4  op code: 0 or, 1 and, 2 add, 3 sub, 4 mul, 5 addi, 6 lw, 7 sw, 8 beq; all others illegal.
REQ-009 rd_i, rs1_i, rs2_i  in  5 each  register indices.
REQ-010 imm_i  in  12  immediate; for beq it holds branch offset bits [12:1].
REQ-011 mem_we_o  out  1  instruction-memory write request.
REQ-012 mem_addr_o  out  32  write byte address.
REQ-013 mem_data_o  out  32  encoded RV32 instruction word.
REQ-014 mem_ack_i  in  1  memory accepted the write.
REQ-015 full_o  out  1  DEPTH words written.
REQ-016 err_o  out  1  sticky illegal-op flag.

Function
REQ-017 Encoding SHALL be R-type {funct7,rs2,rs1,funct3,rd,7'b0110011} with funct7/funct3 values or 0000000/110, and 0000000/111, add 0000000/000, sub 0100000/000, mul 0000001/000.
REQ-018 addi SHALL encode as {imm,rs1,000,rd,0010011}, lw as {imm,rs1,010,rd,0000011}, sw as {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
REQ-019 beq SHALL encode as {imm_i[11],imm_i[9:4],rs2,rs1,000,imm_i[3:0],imm_i[10],1100011}.
REQ-020 Fields not used by a format (rd for sw/beq, rs2 for I-type, imm_i for R-type) SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, WRITE, FULL and ERR.
REQ-022 op_ready_o SHALL be high only in IDLE.
REQ-023 On acceptance the encoded word and current address SHALL be registered; mem_we_o SHALL assert in the next cycle (latency 1) in state WRITE.
REQ-024 In WRITE, mem_we_o, mem_addr_o and mem_data_o SHALL hold stable until the cycle in which mem_ack_i is sampled high.
REQ-025 On ack, the address SHALL advance by 4 and the counter by 1; the next state SHALL be FULL if the counter reaches DEPTH, else IDLE.
REQ-026 An ack in the same cycle as the write assertion SHALL complete the write, so the one-word throughput is 2 cycles.
REQ-027 In FULL, full_o SHALL be 1 and all ops SHALL be refused; only start_i or reset leaves FULL.
REQ-028 start_i SHALL have priority in every state: the pending write is abandoned (mem_we_o low the next cycle), then IDLE, address ADDR_BASE, counter 0, err_o 0.
REQ-029 mem_ack_i SHALL be ignored outside WRITE.
REQ-030 The address SHALL never wrap, because FULL stops it at ADDR_BASE+4*DEPTH.

Reset
REQ-031 On rst_i, regardless of clock: state IDLE, mem_we_o 0, mem_addr_o ADDR_BASE, mem_data_o 0, counter 0, full_o 0, err_o 0.
REQ-032 Reset during WRITE SHALL drop mem_we_o immediately, and the word SHALL not count.

Configuration
REQ-033 With INSTR_ENC_ILLEGAL_TRAP_EN defined, an accepted illegal op SHALL enter ERR, set err_o and perform no write; ERR refuses ops until start_i.
REQ-034 Without INSTR_ENC_ILLEGAL_TRAP_EN, an illegal op SHALL be written as NOP 32'h0000_0013, and err_o SHALL be tied 0.

Structure
REQ-035 Package instr_enc_pkg SHALL hold the op-code enum, the opcode/funct3/funct7 constants, the NOP constant and the FSM state typedef.
REQ-036 The combinational word formatter SHALL be a sub-module instr_enc_fmt (inputs op plus fields, outputs word and legal flag); the FSM, counter and address logic live in instr_encoder.

Verification
REQ-037 add rd=3, rs1=1, rs2=2 with ack the same cycle -> one write, mem_addr_o 0x0, mem_data_o 0x002081B3.
REQ-038 Sequence sub x5,x6,x7; addi x1,x0,imm 0xFFF; sw rs2=2, rs1=1, imm 8; beq rs1=1, rs2=2, imm_i 4 -> data 0x407302B3, 0xFFF00093, 0x0020A423, 0x00208463 at addresses 0x0, 0x4, 0x8, 0xC.
REQ-039 mem_ack_i delayed 3 cycles -> mem_we/addr/data stable for 4 cycles, op_ready_o low throughout, one write counted.
REQ-040 DEPTH=4 with 5 ops offered -> 4 writes, full_o=1, 5th op never readied; start_i -> next write at ADDR_BASE.
REQ-041 op_i=4'hF -> with macro, err_o=1 and no write; without macro, write of 0x00000013.
REQ-042 start_i pulsed and rst_i asserted mid-WRITE (separate runs) -> mem_we_o drops, counter 0, next accepted op writes at 0x0.
